ram_ctrl: RTL and testbench

- Parametrised, byte-addressed, big-endian RAM with a controller that serves the data path's byte, halfword and word loads and stores.
- Uses the MOV/MFC handshake with a configurable number of wait states.
- Includes a byte-wide debug port so benches can preload and dump memory through pins, without hierarchical pokes into the array.
- Sits between the data path's memory address and data registers and the memory array. It replaces the fixed 512-byte RAM.

---
 rtl/ram_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ram_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// Byte-addressed big-endian RAM with a MOV/MFC handshake controller and a byte-wide debug port.
// Serves byte, halfword and word loads/stores after a configurable number of wait states.
module ram_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 9,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                  i_main_clk,
   input  logic                  i_reset,
   input  logic                  i_mov,
   input  logic                  i_rw,
   input  logic [1:0]            i_size,
   input  logic                  i_signed_ld,
   input  logic [ADDR_WIDTH-1:0] i_address,
   input  logic [DATA_WIDTH-1:0] i_data_in,
   output logic [DATA_WIDTH-1:0] o_data_out,
   output logic                  o_mfc,
   output logic                  o_err,
   input  logic                  i_dbg_en,
   input  logic                  i_dbg_we,
   input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
   input  logic [7:0]            i_dbg_wdata,
   output logic [7:0]            o_dbg_rdata,
   output logic                  o_dbg_busy
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;

   state_t                r_state;
   logic [3:0]            r_cnt;
   logic                  r_rw;
   logic [1:0]            r_size;
   logic                  r_signed;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_mfc;
   logic                  r_err;
   logic [7:0]            r_dbg_rdata;
   logic [7:0]            r_mem [Depth];

   logic                  w_access;
   logic                  w_dbg_ok;
   logic [2:0]            w_nm1;
   logic                  w_misalign;
   logic [ADDR_WIDTH:0]   w_last;
   logic                  w_fault;
   logic [ADDR_WIDTH-1:0] w_a1, w_a2, w_a3;
   logic [7:0]            w_b0, w_b1, w_b2, w_b3;
   logic [DATA_WIDTH-1:0] w_rdata;

   // The access happens on the edge that leaves WAIT with the counter exhausted. WAIT is always
   // entered, so mfc rises WAIT_STATES+1 edges after the request is sampled, even for zero waits.
   assign w_access = (r_state == StWait) && (r_cnt == 4'd0);
   // Debug port only owns the array when the controller is idle and no request is pending.
   assign w_dbg_ok = (r_state == StIdle) && !i_mov && i_dbg_en;

   assign w_a1 = r_addr + ADDR_WIDTH'(1);
   assign w_a2 = r_addr + ADDR_WIDTH'(2);
   assign w_a3 = r_addr + ADDR_WIDTH'(3);
   assign w_b0 = r_mem[r_addr];
   assign w_b1 = r_mem[w_a1];
   assign w_b2 = r_mem[w_a2];
   assign w_b3 = r_mem[w_a3];

   // Fault detection: illegal size, misalignment, or last byte beyond the top of the array.
   always_comb begin
      w_nm1      = 3'd0;
      w_misalign = 1'b0;
      case (r_size)
         2'b00:   w_nm1 = 3'd0;
         2'b01:   begin w_nm1 = 3'd1; w_misalign = r_addr[0];      end
         2'b10:   begin w_nm1 = 3'd3; w_misalign = |r_addr[1:0];   end
         default: begin w_nm1 = 3'd0; w_misalign = 1'b1;           end
      endcase
      w_last  = {1'b0, r_addr} + (ADDR_WIDTH + 1)'(w_nm1);
      w_fault = w_misalign | w_last[ADDR_WIDTH];
   end

   // Big-endian read assembly with optional sign extension.
   always_comb begin
      w_rdata = {w_b0, w_b1, w_b2, w_b3};
      case (r_size)
         2'b00:   w_rdata = {{24{r_signed & w_b0[7]}}, w_b0};
         2'b01:   w_rdata = {{16{r_signed & w_b0[7]}}, w_b0, w_b1};
         default: w_rdata = {w_b0, w_b1, w_b2, w_b3};
      endcase
   end

   // Array writes: all bytes of a store land on one edge; not reset so contents survive reset.
   always_ff @(posedge i_main_clk) begin
      if (w_access && !w_fault && !r_rw) begin
         case (r_size)
            2'b00: r_mem[r_addr] <= r_wdata[7:0];
            2'b01: begin
               r_mem[r_addr] <= r_wdata[15:8];
               r_mem[w_a1]   <= r_wdata[7:0];
            end
            2'b10: begin
               r_mem[r_addr] <= r_wdata[31:24];
               r_mem[w_a1]   <= r_wdata[23:16];
               r_mem[w_a2]   <= r_wdata[15:8];
               r_mem[w_a3]   <= r_wdata[7:0];
            end
            default: ;
         endcase
      end else if (w_dbg_ok && i_dbg_we) begin
         r_mem[i_dbg_addr] <= i_dbg_wdata;
      end
   end

   // Registered debug read byte.
   always_ff @(posedge i_main_clk or posedge i_reset) begin
      if (i_reset) begin
         r_dbg_rdata <= 8'h00;
      end else if (w_dbg_ok && !i_dbg_we) begin
         r_dbg_rdata <= r_mem[i_dbg_addr];
      end
   end

   // Controller FSM with registered handshake and read-data outputs.
   always_ff @(posedge i_main_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_cnt      <= 4'd0;
         r_rw       <= 1'b1;
         r_size     <= 2'b00;
         r_signed   <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_data_out <= '0;
         r_mfc      <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (i_mov) begin
                  r_rw     <= i_rw;
                  r_size   <= i_size;
                  r_signed <= i_signed_ld;
                  r_addr   <= i_address;
                  r_wdata  <= i_data_in;
                  r_cnt    <= 4'(WAIT_STATES);
                  r_state  <= StWait;
               end
            end
            StWait: begin
               if (r_cnt == 4'd0) begin
                  r_state <= StDone;
                  r_mfc   <= 1'b1;
                  r_err   <= w_fault;
                  if (!w_fault && r_rw) begin
                     r_data_out <= w_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            StDone: begin
               // mov held high here is the same request, not a new one.
               if (!i_mov) begin
                  r_state <= StIdle;
                  r_mfc   <= 1'b0;
                  r_err   <= 1'b0;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_data_out  = r_data_out;
   assign o_mfc       = r_mfc;
   assign o_err       = r_err;
   assign o_dbg_rdata = r_dbg_rdata;
   assign o_dbg_busy  = (r_state != StIdle) || i_mov;

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: a main instance (2 wait states) and a zero-wait instance share
// all inputs; expected read data/err are queued per request and checked on each mfc rise.
module tb_ram_ctrl;

   localparam int AW = 9;
   localparam int WS = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          mov, rw, sgn;
   logic [1:0]    size;
   logic [AW-1:0] addr;
   logic [31:0]   din;
   logic          dbg_en, dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [7:0]    dbg_wdata;

   logic [31:0]   dout, dout0;
   logic          mfc, mfc0, err, err0, busy, busy0;
   logic [7:0]    dbg_rdata, dbg_rdata0;

   int            checks   = 0;
   int            failures = 0;
   logic [32:0]   sb_q[$];

   always #5 clk = ~clk;

   ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_STATES(WS)) u_dut (
      .i_main_clk(clk), .i_reset(rst), .i_mov(mov), .i_rw(rw), .i_size(size),
      .i_signed_ld(sgn), .i_address(addr), .i_data_in(din), .o_data_out(dout), .o_mfc(mfc),
      .o_err(err), .i_dbg_en(dbg_en), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
      .i_dbg_wdata(dbg_wdata), .o_dbg_rdata(dbg_rdata), .o_dbg_busy(busy)
   );

   ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
      .i_main_clk(clk), .i_reset(rst), .i_mov(mov), .i_rw(rw), .i_size(size),
      .i_signed_ld(sgn), .i_address(addr), .i_data_in(din), .o_data_out(dout0), .o_mfc(mfc0),
      .o_err(err0), .i_dbg_en(dbg_en), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
      .i_dbg_wdata(dbg_wdata), .o_dbg_rdata(dbg_rdata0), .o_dbg_busy(busy0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Monitor: on every mfc rise of the main instance, pop and compare.
   initial begin
      logic        prev;
      logic [32:0] e;
      prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (mfc === 1'b1 && prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected_mfc actual=mfc_rise required=no_rise");
            end else begin
               e = sb_q.pop_front();
               check("sb_data", dout, e[31:0]);
               check("sb_err", {31'b0, err}, {31'b0, e[32]});
            end
         end
         prev = mfc;
      end
   end

   task automatic dbg_write(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk);
      dbg_en = 1'b1; dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
      @(negedge clk);
      dbg_en = 1'b0; dbg_we = 1'b0;
   endtask

   task automatic dbg_read(input logic [AW-1:0] a, input logic [7:0] exp, input string name);
      @(negedge clk);
      dbg_en = 1'b1; dbg_we = 1'b0; dbg_addr = a;
      @(posedge clk);
      #1;
      check(name, {24'b0, dbg_rdata}, {24'b0, exp});
      dbg_en = 1'b0;
   endtask

   // One request; hold = extra cycles mov stays high after mfc with a debug write attempted.
   task automatic mem_op(input logic r, input logic [1:0] sz, input logic sg, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e,
                         input int hold, input string name);
      int n;
      n = 0;
      sb_q.push_back({exp_e, exp_d});
      @(negedge clk);
      mov = 1'b1; rw = r; size = sz; sgn = sg; addr = a; din = d;
      @(posedge clk);
      // Request fields must be latched: scramble them after the sampling edge.
      @(negedge clk);
      rw = ~r; size = ~sz; sgn = ~sg; addr = ~a; din = ~d;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) check({name, "_ws0_mfc"}, {31'b0, mfc0}, 32'd1);
         if (mfc === 1'b1) begin
            n = i;
            break;
         end
      end
      check({name, "_latency"}, 32'(n), 32'(WS + 1));
      check({name, "_ws0_data"}, dout0, exp_d);
      check({name, "_ws0_err"}, {31'b0, err0}, {31'b0, exp_e});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         dbg_en = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h040; dbg_wdata = 8'hEE;
         @(posedge clk);
         #1;
         check({name, "_hold_mfc"}, {31'b0, mfc}, 32'd1);
         check({name, "_hold_busy"}, {31'b0, busy}, 32'd1);
      end
      @(negedge clk);
      mov = 1'b0; dbg_en = 1'b0; dbg_we = 1'b0;
      @(posedge clk);
      #1;
      check({name, "_mfc_drop"}, {31'b0, mfc}, 32'd0);
      check({name, "_err_drop"}, {31'b0, err}, 32'd0);
      check({name, "_data_hold"}, dout, exp_d);
   endtask

   initial begin
      rst = 1'b1; mov = 1'b0; rw = 1'b1; size = 2'b00; sgn = 1'b0; addr = '0; din = '0;
      dbg_en = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      #1;
      check("rst_data_out", dout, 32'h0);
      check("rst_mfc", {31'b0, mfc}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_dbg_rdata", {24'b0, dbg_rdata}, 32'd0);
      check("rst_dbg_busy", {31'b0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Preload and word read.
      dbg_write(9'h000, 8'hE3); dbg_write(9'h001, 8'hA0);
      dbg_write(9'h002, 8'h10); dbg_write(9'h003, 8'h05);
      mem_op(1'b1, 2'b10, 1'b0, 9'h000, 32'h0, 32'hE3A01005, 1'b0, 0, "rd_word0");

      // Byte / halfword reads, signed and unsigned.
      dbg_write(9'h008, 8'h80); dbg_write(9'h009, 8'h7F);
      mem_op(1'b1, 2'b01, 1'b1, 9'h008, 32'h0, 32'hFFFF807F, 1'b0, 0, "rd_hw8_s");
      mem_op(1'b1, 2'b00, 1'b1, 9'h009, 32'h0, 32'h0000007F, 1'b0, 0, "rd_b9_s");
      mem_op(1'b1, 2'b00, 1'b1, 9'h008, 32'h0, 32'hFFFFFF80, 1'b0, 0, "rd_b8_s");
      mem_op(1'b1, 2'b00, 1'b0, 9'h008, 32'h0, 32'h00000080, 1'b0, 0, "rd_b8_u");

      // Stores then debug dump.
      mem_op(1'b0, 2'b10, 1'b0, 9'h020, 32'h12345678, 32'h00000080, 1'b0, 0, "wr_word20");
      mem_op(1'b0, 2'b00, 1'b0, 9'h021, 32'hFFFFFFAB, 32'h00000080, 1'b0, 0, "wr_byte21");
      dbg_read(9'h020, 8'h12, "dump20");
      dbg_read(9'h021, 8'hAB, "dump21");
      dbg_read(9'h022, 8'h56, "dump22");
      dbg_read(9'h023, 8'h78, "dump23");
      mem_op(1'b1, 2'b10, 1'b0, 9'h020, 32'h0, 32'h12AB5678, 1'b0, 0, "rd_word20");

      // Top-of-array halfword is legal; faults leave array and data_out untouched.
      dbg_write(9'h1FE, 8'hC3); dbg_write(9'h1FF, 8'h5A);
      mem_op(1'b1, 2'b01, 1'b0, 9'h1FE, 32'h0, 32'h0000C35A, 1'b0, 0, "rd_hw1fe");
      mem_op(1'b1, 2'b10, 1'b0, 9'h002, 32'h0, 32'h0000C35A, 1'b1, 0, "flt_word2");
      mem_op(1'b0, 2'b01, 1'b0, 9'h1FF, 32'h0000BEEF, 32'h0000C35A, 1'b1, 0, "flt_hw1ff");
      dbg_read(9'h1FF, 8'h5A, "flt_hw1ff_mem");
      dbg_read(9'h1FE, 8'hC3, "flt_hw1fe_mem");
      mem_op(1'b0, 2'b11, 1'b0, 9'h000, 32'hFFFFFFFF, 32'h0000C35A, 1'b1, 0, "flt_size3");
      dbg_read(9'h000, 8'hE3, "flt_size3_mem");

      // Held mov with debug write attempt in DONE.
      dbg_write(9'h040, 8'h11);
      mem_op(1'b1, 2'b00, 1'b0, 9'h040, 32'h0, 32'h00000011, 1'b0, 5, "hold_rd40");
      dbg_read(9'h040, 8'h11, "hold_mem40");

      // Reset in the middle of a word write.
      dbg_write(9'h010, 8'h00); dbg_write(9'h011, 8'h00);
      dbg_write(9'h012, 8'h00); dbg_write(9'h013, 8'h00);
      @(negedge clk);
      mov = 1'b1; rw = 1'b0; size = 2'b10; sgn = 1'b0; addr = 9'h010; din = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1; mov = 1'b0;
      #1;
      check("midrst_mfc", {31'b0, mfc}, 32'd0);
      check("midrst_idle", {31'b0, busy}, 32'd0);
      check("midrst_data", dout, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      mem_op(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 32'h00000000, 1'b0, 0, "midrst_rd10");
      dbg_read(9'h013, 8'h00, "midrst_mem13");

      repeat (3) @(posedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
